// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - scan controller for a 4-digit multiplexed seven-segment display
//
// Purpose:
//   Walks an active-low anode ring across four digits and decodes the matching
//   nibble of the display value to segments and decimal point. New values are
//   offered through a one-entry pending buffer and only reach the display at a
//   frame boundary (or right away while idle), so a scan never shows a torn value.
//
// Ports:
//   clk_500     in   1   scan clock, all state on posedge
//   reset       in   1   asynchronous, active-low
//   en          in   1   1 = scan, 0 = display off
//   blank_lz    in   1   1 = blank leading zero digits (digit0 never blanked)
//   upd_valid   in   1   new value offered
//   upd_data    in  16   new value, digit0 = [3:0] .. digit3 = [15:12]
//   upd_dp      in   4   decimal point per digit, 1 = lit
//   upd_ready   out  1   pending buffer empty
//   an          out  4   anode select, active-low, at most one low
//   seg         out  7   {g,f,e,d,c,b,a}
//   dp          out  1   decimal point
//   frame_done  out  1   one-cycle pulse on the digit3 -> digit0 wrap

module seg_scan_ctrl #(
  parameter int unsigned DWELL          = 1,
  parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
  input  logic        clk_500,
  input  logic        reset,
  input  logic        en,
  input  logic        blank_lz,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic        upd_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN0,
    ST_SCAN1,
    ST_SCAN2,
    ST_SCAN3
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [6:0] SEG_OFF    = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic       DP_OFF     = ACTIVE_LOW_SEG;

  state_t      state_q, state_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        wrap;

  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_full_q, pend_full_d;
  logic        promote, capture;

  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q;

  logic        active;
  logic [1:0]  sel;
  logic [3:0]  nib;
  logic [3:0]  lz;
  logic [6:0]  seg_raw;
  logic        dp_raw;

  // Active-low hex font.
  function automatic logic [6:0] decode_hex(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state logic: each digit is held for DWELL cycles, en low aborts at once.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    wrap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SCAN0;
          dwell_d = 8'd0;
        end
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
          dwell_d = 8'd0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          case (state_q)
            ST_SCAN0: state_d = ST_SCAN1;
            ST_SCAN1: state_d = ST_SCAN2;
            ST_SCAN2: state_d = ST_SCAN3;
            default: begin
              state_d = ST_SCAN0;
              wrap    = 1'b1;
            end
          endcase
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
    endcase
  end

  // Double buffer. Promotion only looks at what was pending before this edge,
  // so a value captured on a wrap edge waits for the following frame end.
  always_comb begin
    promote     = pend_full_q && (wrap || (state_q == ST_IDLE));
    capture     = upd_valid && !pend_full_q;
    disp_val_d  = promote ? pend_val_q : disp_val_q;
    disp_dp_d   = promote ? pend_dp_q : disp_dp_q;
    pend_val_d  = capture ? upd_data : pend_val_q;
    pend_dp_d   = capture ? upd_dp : pend_dp_q;
    pend_full_d = capture || (pend_full_q && !promote);
  end

  // Output decode is taken from the state and value being entered, so the
  // registered pins match the new state on the same edge.
  always_comb begin
    active = 1'b1;
    sel    = 2'd0;
    an_d   = 4'b1111;
    case (state_d)
      ST_SCAN0: begin sel = 2'd0; an_d = 4'b1110; end
      ST_SCAN1: begin sel = 2'd1; an_d = 4'b1101; end
      ST_SCAN2: begin sel = 2'd2; an_d = 4'b1011; end
      ST_SCAN3: begin sel = 2'd3; an_d = 4'b0111; end
      default:  active = 1'b0;
    endcase

    // lz[i] = nibbles i..3 all zero; digit0 is never a leading zero.
    lz = {~|disp_val_d[15:12], ~|disp_val_d[15:8], ~|disp_val_d[15:4], 1'b0};

    nib     = disp_val_d[{sel, 2'b00} +: 4];
    seg_raw = (blank_lz && lz[sel]) ? 7'h7F : decode_hex(nib);
    dp_raw  = ~disp_dp_d[sel];

    if (active) begin
      seg_d = ACTIVE_LOW_SEG ? seg_raw : ~seg_raw;
      dp_d  = ACTIVE_LOW_SEG ? dp_raw : ~dp_raw;
    end else begin
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
    end
  end

  always_ff @(posedge clk_500 or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      dwell_q      <= 8'd0;
      disp_val_q   <= 16'h0000;
      disp_dp_q    <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_full_q  <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
    end
  end

  assign upd_ready  = ~pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - bench for seg_scan_ctrl (DWELL=1 active-low, DWELL=3 inverted)
module tb_seg_scan_ctrl;

  logic        clk_500 = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        blank_lz = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0;
  logic [3:0]  upd_dp = 4'h0;

  logic       rdy1, dp1, fd1, rdy3, dp3, fd3;
  logic [3:0] an1, an3;
  logic [6:0] seg1, seg3;

  int total = 0;
  int bad = 0;

  always #5 clk_500 = ~clk_500;

  seg_scan_ctrl #(.DWELL(1), .ACTIVE_LOW_SEG(1'b1)) dut1 (
    .clk_500(clk_500), .reset(reset), .en(en), .blank_lz(blank_lz),
    .upd_valid(upd_valid), .upd_data(upd_data), .upd_dp(upd_dp),
    .upd_ready(rdy1), .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1));

  seg_scan_ctrl #(.DWELL(3), .ACTIVE_LOW_SEG(1'b0)) dut3 (
    .clk_500(clk_500), .reset(reset), .en(en), .blank_lz(blank_lz),
    .upd_valid(upd_valid), .upd_data(upd_data), .upd_dp(upd_dp),
    .upd_ready(rdy3), .an(an3), .seg(seg3), .dp(dp3), .frame_done(fd3));

  // Reference model: scan position is a plain cycle count since SCAN0 entry;
  // the digit is count/DWELL and a frame ends when the count reaches 4*DWELL.
  int         d_of[2] = '{1, 3};
  bit         al_of[2] = '{1'b1, 1'b0};
  logic [6:0] font[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_on[2], m_pf[2], m_fd[2], m_blank[2];
  int          m_t[2];
  logic [15:0] m_disp[2], m_pv[2];
  logic [3:0]  m_dpv[2], m_pdp[2];

  logic [3:0] an_seq[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_a[4]  = '{7'h40, 7'h0E, 7'h24, 7'h79};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_on[k] = 0; m_pf[k] = 0; m_fd[k] = 0; m_t[k] = 0;
    m_disp[k] = 16'h0; m_dpv[k] = 4'h0; m_pv[k] = 16'h0; m_pdp[k] = 4'h0;
  endtask

  task automatic model_step(input int k);
    bit was_on;
    bit was_pf;
    was_on = m_on[k];
    was_pf = m_pf[k];
    m_fd[k] = 0;
    m_blank[k] = blank_lz;
    if (!was_on) begin
      if (en) begin m_on[k] = 1; m_t[k] = 0; end
    end else if (!en) begin
      m_on[k] = 0;
    end else begin
      m_t[k] = m_t[k] + 1;
      if (m_t[k] == 4 * d_of[k]) begin m_t[k] = 0; m_fd[k] = 1; end
    end
    if (was_pf && (m_fd[k] || !was_on)) begin
      m_disp[k] = m_pv[k]; m_dpv[k] = m_pdp[k]; m_pf[k] = 0;
    end
    if (!was_pf && upd_valid) begin
      m_pv[k] = upd_data; m_pdp[k] = upd_dp; m_pf[k] = 1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int dig;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      logic dp_e;
      an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
      if (m_on[k]) begin
        dig = m_t[k] / d_of[k];
        an_e = 4'hF ^ 4'(1 << dig);
        if (m_blank[k] && dig > 0 && (m_disp[k] >> (4 * dig)) == 16'h0) seg_e = 7'h7F;
        else seg_e = font[4'(m_disp[k] >> (4 * dig))];
        dp_e = ~m_dpv[k][dig];
      end
      if (!al_of[k]) begin seg_e = ~seg_e; dp_e = ~dp_e; end
      chk($sformatf("m_an%0d", k),  16'(k == 0 ? an1 : an3),   16'(an_e));
      chk($sformatf("m_seg%0d", k), 16'(k == 0 ? seg1 : seg3), 16'(seg_e));
      chk($sformatf("m_dp%0d", k),  16'(k == 0 ? dp1 : dp3),   16'(dp_e));
      chk($sformatf("m_rdy%0d", k), 16'(k == 0 ? rdy1 : rdy3), 16'(!m_pf[k]));
      chk($sformatf("m_fd%0d", k),  16'(k == 0 ? fd1 : fd3),   16'(m_fd[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk_500);
    for (int k = 0; k < 2; k++) begin
      if (!reset) model_reset(k);
      else model_step(k);
    end
    #1;
    check_all();
  endtask

  task automatic wait_fd1();
    int n;
    n = 0;
    do begin tick(); n++; end while (!fd1 && n < 20);
    chk("wait_fd1", 16'(fd1), 16'h1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin model_reset(k); m_blank[k] = 0; end

    // Reset state
    tick(); tick();
    chk("rst_an", 16'(an1), 16'hF);
    chk("rst_seg", 16'(seg1), 16'h7F);
    chk("rst_dp", 16'(dp1), 16'h1);
    chk("rst_rdy", 16'(rdy1), 16'h1);
    chk("rst_seg_inv", 16'(seg3), 16'h00);
    reset = 1'b1;

    // Load 12F0 while idle, then scan
    upd_valid = 1'b1; upd_data = 16'h12F0; upd_dp = 4'h0;
    tick();
    chk("idle_cap_rdy", 16'(rdy1), 16'h0);
    upd_valid = 1'b0;
    tick();
    chk("idle_prom_rdy", 16'(rdy1), 16'h1);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_an", 16'(an1), 16'(an_seq[i]));
      chk("a_seg", 16'(seg1), 16'(seg_a[i]));
      chk("a_fd", 16'(fd1), 16'h0);
    end
    tick();
    chk("a_wrap_fd", 16'(fd1), 16'h1);
    chk("a_wrap_an", 16'(an1), 16'hE);

    // Leading-zero blanking of 0070
    blank_lz = 1'b1;
    upd_valid = 1'b1; upd_data = 16'h0070;
    tick();
    upd_valid = 1'b0;
    wait_fd1();
    chk("lz_d0", 16'(seg1), 16'h40);
    tick(); chk("lz_d1", 16'(seg1), 16'h78); chk("lz_an1", 16'(an1), 16'hD);
    tick(); chk("lz_d2", 16'(seg1), 16'h7F); chk("lz_an2", 16'(an1), 16'hB);
    tick(); chk("lz_d3", 16'(seg1), 16'h7F); chk("lz_an3", 16'(an1), 16'h7);
    blank_lz = 1'b0;

    // Mid-frame update AAAA while showing 1111
    upd_valid = 1'b1; upd_data = 16'h1111;
    tick();
    upd_valid = 1'b0;
    wait_fd1();
    chk("mf_d0_old", 16'(seg1), 16'h79);
    upd_valid = 1'b1; upd_data = 16'hAAAA;
    tick();
    chk("mf_rdy_fall", 16'(rdy1), 16'h0);
    chk("mf_d1_old", 16'(seg1), 16'h79);
    upd_valid = 1'b0;
    tick(); chk("mf_d2_old", 16'(seg1), 16'h79);
    tick(); chk("mf_d3_old", 16'(seg1), 16'h79);
    tick();
    chk("mf_fd", 16'(fd1), 16'h1);
    chk("mf_new0", 16'(seg1), 16'h08);
    chk("mf_rdy_back", 16'(rdy1), 16'h1);
    for (int i = 1; i < 4; i++) begin tick(); chk("mf_new", 16'(seg1), 16'h08); end

    // Held upd_valid: second value waits for promotion of the first
    upd_valid = 1'b1; upd_data = 16'h1234;
    tick();
    upd_data = 16'hBEEF;
    wait_fd1();
    chk("hold_first_d0", 16'(seg1), 16'h19);
    chk("hold_rdy", 16'(rdy1), 16'h1);
    tick();
    chk("hold_cap2", 16'(rdy1), 16'h0);
    chk("hold_first_d1", 16'(seg1), 16'h30);
    upd_valid = 1'b0;
    tick(); chk("hold_first_d2", 16'(seg1), 16'h24);
    tick(); chk("hold_first_d3", 16'(seg1), 16'h79);
    tick();
    chk("hold_second_fd", 16'(fd1), 16'h1);
    chk("hold_second_d0", 16'(seg1), 16'h0E);
    chk("hold_second_rdy", 16'(rdy1), 16'h1);

    // DWELL=3: drop en during SCAN2, then restart
    begin
      int n;
      n = 0;
      while (an3 !== 4'b1011 && n < 40) begin tick(); n++; end
      chk("wait_scan2", 16'(an3), 16'hB);
    end
    en = 1'b0;
    tick();
    chk("abort_an3", 16'(an3), 16'hF);
    chk("abort_fd3", 16'(fd3), 16'h0);
    chk("abort_an1", 16'(an1), 16'hF);
    en = 1'b1;
    tick(); chk("restart_c1", 16'(an3), 16'hE);
    tick(); chk("restart_c2", 16'(an3), 16'hE);
    tick(); chk("restart_c3", 16'(an3), 16'hE);
    tick(); chk("restart_next", 16'(an3), 16'hD);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      upd_valid = 1'($urandom_range(0, 1));
      upd_data  = 16'($urandom);
      upd_dp    = 4'($urandom);
      blank_lz  = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset in the middle of SCAN2
    en = 1'b1; upd_valid = 1'b0; blank_lz = 1'b0;
    begin
      int n;
      n = 0;
      while (an1 !== 4'b1011 && n < 10) begin tick(); n++; end
      chk("wait_rst_scan2", 16'(an1), 16'hB);
    end
    #3;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    chk("arst_an", 16'(an1), 16'hF);
    chk("arst_seg", 16'(seg1), 16'h7F);
    chk("arst_dp", 16'(dp1), 16'h1);
    chk("arst_rdy", 16'(rdy1), 16'h1);
    chk("arst_an3", 16'(an3), 16'hF);
    chk("arst_seg3", 16'(seg3), 16'h00);
    chk("arst_dp3", 16'(dp3), 16'h0);
    check_all();
    tick();
    reset = 1'b1;
    en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan controller for the 4-digit multiplexed seven-segment display on the FPGA board.
- Sequences the active-low anode ring, picks the matching nibble of a 16-bit display value, and decodes it to segments and decimal point.
- Owns an update handshake that double-buffers new values and applies them only at frame boundaries, so the display never tears mid-scan.
- Sits between CPU debug/status logic (PC, register, or result display) and the board pins.

Parameters:
- DWELL, default 1: clk_500 cycles spent on each digit (1..255).
- ACTIVE_LOW_SEG, default 1: 1 = seg/dp driven active-low; 0 = seg/dp inverted. an is always active-low.

Ports:
- clk_500  in  1  scan clock, all state on posedge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- en  in  1  1 = scan, 0 = display off (IDLE).
- blank_lz  in  1  1 = blank leading zero digits.
- upd_valid  in  1  new value offered.
- upd_data  in  16  new value; digit0 = [3:0] … digit3 = [15:12].
- upd_dp  in  4  decimal point per digit, 1 = lit; bit i = digit i.
- upd_ready  out  1  pending buffer empty, can accept.
- an  out  4  anode select, active-low, at most one 0.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- frame_done  out  1  one-cycle pulse at end of digit3 dwell.

Behaviour:
- Reset (reset==0, async) values:
  - an=4'b1111, seg=7'h7F, dp=1 (polarity per ACTIVE_LOW_SEG), upd_ready=1, frame_done=0.
  - Display value=16'h0000, display dp=4'h0, pending empty, dwell=0, state IDLE.
- States:
  - IDLE: an=1111, seg all off.
  - SCAN0..SCAN3: an=1110, 1101, 1011, 0111 respectively.
- Transitions:
  - IDLE->SCAN0 when en=1; dwell cleared.
  - SCANi holds for DWELL cycles, then ->SCAN(i+1).
  - SCAN3 end -> SCAN0 (wrap), with frame_done=1 for that edge.
  - en=0 in any SCAN -> IDLE at next edge, aborting the frame with no frame_done.
- Outputs an/seg/dp are registered and reflect the state entered at the same edge; no combinational path from inputs to outputs.
- Handshake:
  - upd_ready = pending empty.
  - Capture occurs on a posedge where upd_valid & upd_ready; the pending buffer is then full and upd_ready=0.
  - upd_valid while not ready is ignored (not queued); the source must hold it.
- Promotion (pending -> display, pending emptied, upd_ready=1 next cycle):
  - occurs on the frame_done edge, or
  - on the first edge after capture while in IDLE.
  - A capture on the same edge as frame_done (pending was empty) stays pending until the next frame end.
- Decode (active-low table, seg=7'h7F blank):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blank (blank_lz=1): digit i (i=3..1) is blanked if nibbles i..3 are all zero.
  - Digit0 is never blanked.
  - an still selects the blanked digit; dp is unaffected by blanking.
- ACTIVE_LOW_SEG=0 inverts seg and dp only.

Test Plan:
- Reset mid-scan (reset=0 while an=1011) -> an=1111, seg=7F, dp=1, upd_ready=1 with no clock edge needed.
- DWELL=1, en=1, value 16'h12F0 loaded in IDLE -> an cycles 1110,1101,1011,0111 with seg 40,0E,24,79; frame_done pulses on the 0111->1110 edge.
- blank_lz=1, value 16'h0070 -> digit3 and digit2 seg=7F, digit1 seg=78, digit0 seg=40; all four anodes still scanned.
- Mid-frame update 16'hAAAA while showing 16'h1111 -> upd_ready falls next cycle; remaining digits of the frame show 79; after the frame_done edge every digit shows 08 and upd_ready=1.
- upd_valid held during full pending with a second value -> second value captured only after promotion; no value lost or duplicated.
- DWELL=3, en dropped during SCAN2 -> an=1111 next edge, no frame_done; en=1 restarts at SCAN0 holding for exactly 3 cycles.
